mem_word_bridge: RTL and testbench

MEM_WORD_BRIDGE -- requirements
Module: mem_word_bridge

---
 rtl/mem_word_bridge.sv | 151 +++++++++++++++
 tb/tb_mem_word_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_bridge.sv
// Bridges 8/16-bit CPU accesses onto a byte-wide memory handshake.
// Word accesses become two byte accesses at addr and addr+1, with a mandatory idle gap between them.
module mem_word_bridge #(
  parameter logic BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic        cpu_word,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_valid,
  output logic        mem_write,
  input  logic        mem_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ0 = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_REQ1 = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]  r_state,     w_state_nxt;
  logic [15:0] r_addr,      w_addr_nxt;
  logic [15:0] r_wdata,     w_wdata_nxt;
  logic        r_write,     w_write_nxt;
  logic        r_word,      w_word_nxt;
  logic [7:0]  r_byte0,     w_byte0_nxt;
  logic [7:0]  r_byte1,     w_byte1_nxt;
  logic [15:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic        r_cpu_ready, w_cpu_ready_nxt;
  logic [15:0] r_mem_addr,  w_mem_addr_nxt;
  logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic        r_mem_valid, w_mem_valid_nxt;
  logic        r_mem_write, w_mem_write_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_write     <= 1'b0;
      r_word      <= 1'b0;
      r_byte0     <= 8'h00;
      r_byte1     <= 8'h00;
      r_cpu_rdata <= 16'h0000;
      r_cpu_ready <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
      r_mem_valid <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_write     <= w_write_nxt;
      r_word      <= w_word_nxt;
      r_byte0     <= w_byte0_nxt;
      r_byte1     <= w_byte1_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_write <= w_mem_write_nxt;
    end
  end

  // Next-state and next-output logic; byte0 is always the byte at the request address
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_write_nxt     = r_write;
    w_word_nxt      = r_word;
    w_byte0_nxt     = r_byte0;
    w_byte1_nxt     = r_byte1;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_cpu_ready_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_write_nxt = r_mem_write;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid && !mem_ready) begin
          w_state_nxt     = S_REQ0;
          w_addr_nxt      = cpu_addr;
          w_wdata_nxt     = cpu_wdata;
          w_write_nxt     = cpu_write;
          w_word_nxt      = cpu_word;
          w_mem_valid_nxt = 1'b1;
          w_mem_write_nxt = cpu_write;
          w_mem_addr_nxt  = cpu_addr;
          w_mem_wdata_nxt = (cpu_word && BIG_ENDIAN) ? cpu_wdata[15:8] : cpu_wdata[7:0];
        end
      end
      S_REQ0: begin
        if (mem_ready) begin
          w_mem_valid_nxt = 1'b0;
          w_mem_write_nxt = 1'b0;
          if (!r_write) w_byte0_nxt = mem_rdata;
          w_state_nxt = r_word ? S_GAP : S_RESP;
        end
      end
      S_GAP: begin
        // Memory must see mem_valid low and clear mem_ready before the second byte
        if (!mem_ready) begin
          w_state_nxt     = S_REQ1;
          w_mem_valid_nxt = 1'b1;
          w_mem_write_nxt = r_write;
          w_mem_addr_nxt  = r_addr + 16'd1;
          w_mem_wdata_nxt = BIG_ENDIAN ? r_wdata[7:0] : r_wdata[15:8];
        end
      end
      S_REQ1: begin
        if (mem_ready) begin
          w_mem_valid_nxt = 1'b0;
          w_mem_write_nxt = 1'b0;
          if (!r_write) w_byte1_nxt = mem_rdata;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_cpu_ready_nxt = 1'b1;
        if (!r_write) begin
          if (!r_word)        w_cpu_rdata_nxt = {8'h00, r_byte0};
          else if (BIG_ENDIAN) w_cpu_rdata_nxt = {r_byte0, r_byte1};
          else                w_cpu_rdata_nxt = {r_byte1, r_byte0};
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_valid = r_mem_valid;
  assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge: little-endian instance 0, big-endian instance 1,
// each attached to its own byte memory model with a programmable ready delay.
module tb_mem_word_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn    = 1'b0;
  logic [15:0]      cpu_addr  = 16'h0000;
  logic [15:0]      cpu_wdata = 16'h0000;
  logic             cpu_write = 1'b0;
  logic             cpu_word  = 1'b0;
  logic [1:0]       cpu_valid = 2'b00;
  logic [1:0][15:0] cpu_rdata;
  logic [1:0]       cpu_ready;
  logic [1:0][15:0] mem_addr;
  logic [1:0][7:0]  mem_wdata;
  logic [1:0]       mem_valid;
  logic [1:0]       mem_write;
  logic [1:0]       mem_ready = 2'b00;
  logic [1:0][7:0]  mem_rdata = '0;

  logic [7:0] mem [0:1][0:65535];
  int cnt [2] = '{0, 0};
  int lat = 0;

  int checks = 0;
  int errors = 0;

  int          mv_rises = 0;
  int          rdy_pulses = 0;
  logic        prev_mv = 1'b0;
  logic [15:0] last_rise_addr = 16'h0000;

  mem_word_bridge #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .resetn(resetn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata[0]),
    .cpu_valid(cpu_valid[0]), .cpu_write(cpu_write), .cpu_word(cpu_word), .cpu_ready(cpu_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_valid(mem_valid[0]), .mem_write(mem_write[0]), .mem_ready(mem_ready[0])
  );

  mem_word_bridge #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .resetn(resetn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata[1]),
    .cpu_valid(cpu_valid[1]), .cpu_write(cpu_write), .cpu_word(cpu_word), .cpu_ready(cpu_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_valid(mem_valid[1]), .mem_write(mem_write[1]), .mem_ready(mem_ready[1])
  );

  // Byte memory: ready rises lat+1 cycles after mem_valid, clears the cycle after mem_valid drops
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!mem_valid[i]) begin
        mem_ready[i] <= 1'b0;
        cnt[i]       <= 0;
      end else if (!mem_ready[i]) begin
        if (cnt[i] >= lat) begin
          mem_ready[i] <= 1'b1;
          if (mem_write[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
          else              mem_rdata[i]        <= mem[i][mem_addr[i]];
        end else begin
          cnt[i] <= cnt[i] + 1;
        end
      end
    end
  end

  // Observe instance 0 handshake activity mid-cycle
  always @(negedge clk) begin
    if (mem_valid[0] && !prev_mv) begin
      mv_rises++;
      last_rise_addr = mem_addr[0];
    end
    prev_mv = mem_valid[0];
    if (cpu_ready[0]) rdy_pulses++;
  end

  // Issue one request; returns cycles from acceptance edge to cpu_ready and the read data then
  task automatic do_req(input int inst, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic wr, input logic wd, input logic hold,
                        output int cyc, output logic [15:0] rd);
    @(negedge clk);
    cpu_addr        = addr;
    cpu_wdata       = wdata;
    cpu_write       = wr;
    cpu_word        = wd;
    cpu_valid[inst] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cpu_valid[inst] = 1'b0;
    cyc = -1;
    rd  = 16'hxxxx;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (cpu_ready[inst]) begin
        cyc = n;
        rd  = cpu_rdata[inst];
        break;
      end
    end
    cpu_valid[inst] = 1'b0;
    if (cyc < 0) begin
      errors++;
      $display("FAIL req_timeout inst %0d addr %h: no cpu_ready within 60 cycles", inst, addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready[0]); end
    checks++; if (cpu_rdata[0] !== 16'h0000) begin errors++; $display("FAIL reset_cpu_rdata got %h want 0000", cpu_rdata[0]); end
    checks++; if (mem_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid[0]); end
    checks++; if (mem_write[0] !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", mem_write[0]); end
    checks++; if (mem_addr[0] !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr[0]); end
    checks++; if (mem_wdata[0] !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata[0]); end
    checks++; if (mem_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_be_mem_valid got %b want 0", mem_valid[1]); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_byte();
    int cyc;
    logic [15:0] rd;
    do_req(0, 16'h1234, 16'h55AB, 1'b1, 1'b0, 1'b0, cyc, rd);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL byte_wr_latency got %0d want 3", cyc); end
    checks++; if (mem[0][16'h1234] !== 8'hAB) begin errors++; $display("FAIL byte_wr_mem got %h want ab", mem[0][16'h1234]); end
    do_req(0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, cyc, rd);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL byte_rd_latency got %0d want 3", cyc); end
    checks++; if (rd !== 16'h00AB) begin errors++; $display("FAIL byte_rd_data got %h want 00ab", rd); end
    do_req(0, 16'h1235, 16'h9933, 1'b1, 1'b0, 1'b0, cyc, rd);
    checks++; if (rd !== 16'h00AB) begin errors++; $display("FAIL rdata_hold_on_write got %h want 00ab", rd); end
    checks++; if (mem[0][16'h1235] !== 8'h33) begin errors++; $display("FAIL byte_wr2_mem got %h want 33", mem[0][16'h1235]); end
  endtask

  task automatic test_word();
    int cyc;
    logic [15:0] rd;
    #1; mv_rises = 0;
    do_req(0, 16'h2000, 16'hBEEF, 1'b1, 1'b1, 1'b0, cyc, rd);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL word_wr_latency got %0d want 7", cyc); end
    checks++; if (mem[0][16'h2000] !== 8'hEF) begin errors++; $display("FAIL word_wr_lo got %h want ef", mem[0][16'h2000]); end
    checks++; if (mem[0][16'h2001] !== 8'hBE) begin errors++; $display("FAIL word_wr_hi got %h want be", mem[0][16'h2001]); end
    checks++; if (mv_rises !== 2) begin errors++; $display("FAIL word_two_accesses got %0d want 2", mv_rises); end
    checks++; if (last_rise_addr !== 16'h2001) begin errors++; $display("FAIL word_second_addr got %h want 2001", last_rise_addr); end
    do_req(0, 16'h2000, 16'h0000, 1'b0, 1'b1, 1'b0, cyc, rd);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL word_rd_latency got %0d want 7", cyc); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL word_rd_data got %h want beef", rd); end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [15:0] rd;
    do_req(0, 16'hFFFF, 16'h1122, 1'b1, 1'b1, 1'b0, cyc, rd);
    checks++; if (mem[0][16'hFFFF] !== 8'h22) begin errors++; $display("FAIL wrap_lo got %h want 22", mem[0][16'hFFFF]); end
    checks++; if (mem[0][16'h0000] !== 8'h11) begin errors++; $display("FAIL wrap_hi got %h want 11", mem[0][16'h0000]); end
    checks++; if (last_rise_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h want 0000", last_rise_addr); end
    do_req(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, cyc, rd);
    checks++; if (rd !== 16'h1122) begin errors++; $display("FAIL wrap_rd_data got %h want 1122", rd); end
  endtask

  task automatic test_big_endian();
    int cyc;
    logic [15:0] rd;
    do_req(1, 16'h0010, 16'hCAFE, 1'b1, 1'b1, 1'b0, cyc, rd);
    checks++; if (mem[1][16'h0010] !== 8'hCA) begin errors++; $display("FAIL be_wr_lo_addr got %h want ca", mem[1][16'h0010]); end
    checks++; if (mem[1][16'h0011] !== 8'hFE) begin errors++; $display("FAIL be_wr_hi_addr got %h want fe", mem[1][16'h0011]); end
    do_req(1, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, cyc, rd);
    checks++; if (rd !== 16'hCAFE) begin errors++; $display("FAIL be_rd_word got %h want cafe", rd); end
    do_req(1, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, cyc, rd);
    checks++; if (rd !== 16'h00FE) begin errors++; $display("FAIL be_rd_byte got %h want 00fe", rd); end
  endtask

  task automatic test_stretch();
    int cyc;
    logic [15:0] rd;
    lat = 3;
    #1; mv_rises = 0; rdy_pulses = 0;
    do_req(0, 16'h4000, 16'h1357, 1'b1, 1'b1, 1'b1, cyc, rd);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL stretch_wr_latency got %0d want 13", cyc); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rdy_pulses !== 1) begin errors++; $display("FAIL stretch_ready_pulses got %0d want 1", rdy_pulses); end
    checks++; if (mv_rises !== 2) begin errors++; $display("FAIL stretch_accesses got %0d want 2", mv_rises); end
    checks++; if (mem[0][16'h4000] !== 8'h57) begin errors++; $display("FAIL stretch_wr_lo got %h want 57", mem[0][16'h4000]); end
    do_req(0, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1, cyc, rd);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL stretch_rd_latency got %0d want 13", cyc); end
    checks++; if (rd !== 16'h1357) begin errors++; $display("FAIL stretch_rd_data got %h want 1357", rd); end
    do_req(0, 16'h4001, 16'h0000, 1'b0, 1'b0, 1'b1, cyc, rd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL stretch_byte_latency got %0d want 6", cyc); end
    checks++; if (rd !== 16'h0013) begin errors++; $display("FAIL stretch_byte_data got %h want 0013", rd); end
    lat = 0;
  endtask

  task automatic test_reset_gap();
    int cyc;
    logic [15:0] rd;
    do_req(0, 16'h3000, 16'h7788, 1'b1, 1'b1, 1'b0, cyc, rd);
    do_req(0, 16'h3000, 16'h0000, 1'b0, 1'b1, 1'b0, cyc, rd);
    checks++; if (rd !== 16'h7788) begin errors++; $display("FAIL pre_abort_rd got %h want 7788", rd); end
    @(negedge clk);
    cpu_addr = 16'h3000; cpu_wdata = 16'h5566; cpu_write = 1'b1; cpu_word = 1'b1; cpu_valid[0] = 1'b1;
    @(posedge clk);
    #1; cpu_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_valid[0] !== 1'b0 || mem_addr[0] !== 16'h3000) begin
      errors++; $display("FAIL gap_state got valid %b addr %h want 0 3000", mem_valid[0], mem_addr[0]);
    end
    resetn = 1'b0;
    #1;
    checks++; if (cpu_ready[0] !== 1'b0) begin errors++; $display("FAIL abort_cpu_ready got %b want 0", cpu_ready[0]); end
    checks++; if (cpu_rdata[0] !== 16'h0000) begin errors++; $display("FAIL abort_cpu_rdata got %h want 0000", cpu_rdata[0]); end
    checks++; if (mem_valid[0] !== 1'b0) begin errors++; $display("FAIL abort_mem_valid got %b want 0", mem_valid[0]); end
    checks++; if (mem_addr[0] !== 16'h0000) begin errors++; $display("FAIL abort_mem_addr got %h want 0000", mem_addr[0]); end
    checks++; if (mem_wdata[0] !== 8'h00) begin errors++; $display("FAIL abort_mem_wdata got %h want 00", mem_wdata[0]); end
    checks++; if (mem[0][16'h3000] !== 8'h66 || mem[0][16'h3001] !== 8'h77) begin
      errors++; $display("FAIL abort_mem got %h %h want 66 77", mem[0][16'h3000], mem[0][16'h3001]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    do_req(0, 16'h3000, 16'h0000, 1'b0, 1'b1, 1'b0, cyc, rd);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL post_abort_latency got %0d want 7", cyc); end
    checks++; if (rd !== 16'h7766) begin errors++; $display("FAIL post_abort_rd got %h want 7766", rd); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_word();
    test_wrap();
    test_big_endian();
    test_stretch();
    test_reset_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
